// File: rtl/button_press_decoder.sv
// Synchronises a debounced button level into clock_in and classifies operator
// gestures (press, release, short, long, double) as one-cycle registered pulses.
module button_press_decoder #(
   parameter int CNT_WIDTH    = 24,
   parameter int LONG_TICKS   = 6000000,
   parameter int DOUBLE_TICKS = 3000000
) (
   input  logic clock_in,
   input  logic reset,
   input  logic button_level,
   output logic held,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic double_press
);

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      LONG_HELD,
      WAIT_SECOND,
      SECOND_PRESSED
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_TICKS - 1);
   localparam logic [CNT_WIDTH-1:0] DOUBLE_LAST = CNT_WIDTH'(DOUBLE_TICKS - 1);
   localparam logic [CNT_WIDTH-1:0] TIMER_ONE   = CNT_WIDTH'(1);

   logic                 s1;
   logic                 s2;
   logic                 s3;
   logic                 rise;
   logic                 fall;
   state_t               state;
   logic [CNT_WIDTH-1:0] timer;

   // s1/s2 form the synchroniser; s3 only remembers the previous synchronised level
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         s3            <= 1'b0;
         state         <= IDLE;
         timer         <= '0;
         held          <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_press   <= 1'b0;
         long_press    <= 1'b0;
         double_press  <= 1'b0;
      end else begin
         s1            <= button_level;
         s2            <= s1;
         s3            <= s2;
         held          <= s2;
         press_pulse   <= rise;
         release_pulse <= fall;
         short_press   <= 1'b0;
         long_press    <= 1'b0;
         double_press  <= 1'b0;

         // Edge checks come before timer thresholds so an edge always wins a tie
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= PRESSED;
                  timer <= '0;
               end
            end
            PRESSED: begin
               if (fall) begin
                  state <= WAIT_SECOND;
                  timer <= '0;
               end else if (timer == LONG_LAST) begin
                  long_press <= 1'b1;
                  state      <= LONG_HELD;
               end else begin
                  timer <= timer + TIMER_ONE;
               end
            end
            LONG_HELD: begin
               if (fall) state <= IDLE;
            end
            WAIT_SECOND: begin
               if (rise) begin
                  double_press <= 1'b1;
                  state        <= SECOND_PRESSED;
               end else if (timer == DOUBLE_LAST) begin
                  short_press <= 1'b1;
                  state       <= IDLE;
               end else begin
                  timer <= timer + TIMER_ONE;
               end
            end
            SECOND_PRESSED: begin
               if (fall) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
